// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory for the load/store path.
// Byte/half/word access, lane writes, load extension, zero-fill after reset.
module data_mem_ctrl #(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       read_data,
  output logic              fault
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  logic            fault_q, fault_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [MW-1:0]    widx;
  logic             in_range;
  logic             bad;
  logic             accept;
  logic             clr_en;
  logic             wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [31:0]      ext;

  assign idx      = address[ADDR_W-1:2];
  assign widx     = idx[MW-1:0];
  assign in_range = 32'(idx) < 32'(DEPTH);
  assign rword    = mem_q[widx];
  assign rbyte    = rword[{address[1:0], 3'b000} +: 8];
  assign rhalf    = rword[{address[1], 4'b0000} +: 16];

  assign ready     = ready_q;
  assign rvalid    = rvalid_q;
  assign fault     = fault_q;
  assign read_data = rdata_q;

  // Legality, lane selection, load extension and next-state logic.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    rvalid_d  = 1'b0;
    fault_d   = 1'b0;
    rdata_d   = rdata_q;
    clr_en    = 1'b0;
    wr_en     = 1'b0;
    be        = 4'b0000;
    wdata     = write_data;
    ext       = rword;
    bad       = (size == 2'b11)
              | ((size == 2'b01) & address[0])
              | ((size == 2'b10) & (|address[1:0]))
              | ~in_range;
    accept    = (state_q == IDLE) & ready_q & req;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << address[1:0];
        wdata = {4{write_data[7:0]}};
        ext   = {{24{rbyte[7] & ~unsigned_ld}}, rbyte};
      end
      2'b01: begin
        be    = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
        ext   = {{16{rhalf[15] & ~unsigned_ld}}, rhalf};
      end
      default: begin
        be    = 4'b1111;
        wdata = write_data;
        ext   = rword;
      end
    endcase
    unique case (state_q)
      CLEAR: begin
        clr_en    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == MW'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
          ready_d   = 1'b1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (bad) begin
            fault_d = 1'b1;
          end else if (we) begin
            wr_en = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset restarts the fill from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      fault_q   <= fault_d;
      rdata_q   <= rdata_d;
    end
  end

  // Array: zero-fill during CLEAR, otherwise byte-lane store writes.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl.
// Two instances: DEPTH=64 (main) and DEPTH=48 (range boundary).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req48;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [7:0]  address;
  logic [31:0] write_data;

  logic        ready, rvalid, fault;
  logic [31:0] read_data;
  logic        ready48, rvalid48, fault48;
  logic [31:0] read_data48;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(64), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .address(address),
    .write_data(write_data), .ready(ready), .rvalid(rvalid),
    .read_data(read_data), .fault(fault)
  );

  data_mem_ctrl #(.DEPTH(48), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut48 (
    .clk(clk), .reset(reset), .req(req48), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .address(address),
    .write_data(write_data), .ready(ready48), .rvalid(rvalid48),
    .read_data(read_data48), .fault(fault48)
  );

  // One access: drive at negedge, accepted at posedge, return at +1.
  task automatic acc(input bit sel48, input bit w, input logic [1:0] sz,
                     input bit uns, input logic [7:0] a,
                     input logic [31:0] wd);
    @(negedge clk);
    we = w; size = sz; unsigned_ld = uns; address = a; write_data = wd;
    if (sel48) req48 = 1'b1; else req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; req48 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req = 1'b0; req48 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic count_clear(input string nm);
    int cnt = 0;
    while (!ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_tests++;
    if (cnt !== 64) begin
      n_fail++;
      $display("FAIL %s: clear edges %0d, expected 64", nm, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 0; req48 = 0; we = 0; size = 2'b10;
    unsigned_ld = 0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ready, rvalid, fault, read_data} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outs: rdy=%b rv=%b flt=%b rd=%h, expected 0",
               ready, rvalid, fault, read_data);
    end
    @(negedge clk);
    reset = 1'b1;
    count_clear("clear_len");
    acc(0, 0, 2'b10, 0, 8'h3C, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL load_after_clear: rv=%b rd=%h, expected 1 00000000",
               rvalid, read_data);
    end
  endtask

  task automatic test_bytes();
    logic [31:0] exp_b [4];
    exp_b[0] = 32'hFFFFFFEF; exp_b[1] = 32'hFFFFFFBE;
    exp_b[2] = 32'hFFFFFFAD; exp_b[3] = 32'hFFFFFFDE;
    acc(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF);
    n_tests++;
    if (rvalid !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp: rv=%b flt=%b, expected 0 0", rvalid, fault);
    end
    for (int i = 0; i < 4; i++) begin
      acc(0, 0, 2'b00, 0, 8'h10 + 8'(i), '0);
      n_tests++;
      if (rvalid !== 1'b1 || read_data !== exp_b[i]) begin
        n_fail++;
        $display("FAIL sbyte_%0d: rv=%b rd=%h, expected 1 %h",
                 i, rvalid, read_data, exp_b[i]);
      end
    end
    acc(0, 0, 2'b00, 1, 8'h13, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h000000DE) begin
      n_fail++;
      $display("FAIL ubyte: rv=%b rd=%h, expected 1 000000de",
               rvalid, read_data);
    end
    idle_cycle();
    n_tests++;
    if (rvalid !== 1'b0 || read_data !== 32'h000000DE) begin
      n_fail++;
      $display("FAIL rvalid_drop: rv=%b rd=%h, expected 0 000000de",
               rvalid, read_data);
    end
  endtask

  task automatic test_half();
    acc(0, 1, 2'b10, 0, 8'h20, 32'hAABBCCDD);
    acc(0, 1, 2'b01, 0, 8'h22, 32'h99881234);
    acc(0, 0, 2'b10, 0, 8'h20, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h1234CCDD) begin
      n_fail++;
      $display("FAIL half_merge: rv=%b rd=%h, expected 1 1234ccdd",
               rvalid, read_data);
    end
    acc(0, 0, 2'b01, 0, 8'h20, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'hFFFFCCDD) begin
      n_fail++;
      $display("FAIL shalf: rv=%b rd=%h, expected 1 ffffccdd",
               rvalid, read_data);
    end
    acc(0, 0, 2'b01, 1, 8'h22, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h00001234) begin
      n_fail++;
      $display("FAIL uhalf: rv=%b rd=%h, expected 1 00001234",
               rvalid, read_data);
    end
  endtask

  task automatic test_fault();
    acc(0, 1, 2'b10, 0, 8'h21, 32'h11111111);
    n_tests++;
    if (fault !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_store: flt=%b rv=%b, expected 1 0", fault, rvalid);
    end
    idle_cycle();
    n_tests++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_pulse: flt=%b, expected 0", fault);
    end
    acc(0, 0, 2'b10, 0, 8'h20, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h1234CCDD) begin
      n_fail++;
      $display("FAIL no_corrupt: rv=%b rd=%h, expected 1 1234ccdd",
               rvalid, read_data);
    end
    acc(0, 0, 2'b01, 0, 8'h23, '0);
    n_tests++;
    if (fault !== 1'b1 || rvalid !== 1'b0 || read_data !== 32'h1234CCDD) begin
      n_fail++;
      $display("FAIL mis_half: flt=%b rv=%b rd=%h, expected 1 0 1234ccdd",
               fault, rvalid, read_data);
    end
    acc(0, 0, 2'b11, 0, 8'h20, '0);
    n_tests++;
    if (fault !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL size11: flt=%b rv=%b, expected 1 0", fault, rvalid);
    end
  endtask

  task automatic test_depth48();
    acc(1, 0, 2'b10, 0, 8'hC0, '0);
    n_tests++;
    if (fault48 !== 1'b1 || rvalid48 !== 1'b0) begin
      n_fail++;
      $display("FAIL range48: flt=%b rv=%b, expected 1 0",
               fault48, rvalid48);
    end
    acc(1, 1, 2'b10, 0, 8'hBC, 32'h00000055);
    acc(1, 0, 2'b10, 0, 8'hBC, '0);
    n_tests++;
    if (rvalid48 !== 1'b1 || fault48 !== 1'b0 ||
        read_data48 !== 32'h00000055) begin
      n_fail++;
      $display("FAIL last48: rv=%b flt=%b rd=%h, expected 1 0 00000055",
               rvalid48, fault48, read_data48);
    end
  endtask

  task automatic test_reset_mid();
    acc(0, 0, 2'b10, 0, 8'h10, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_reset_load: rv=%b rd=%h, expected 1 deadbeef",
               rvalid, read_data);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (rvalid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rv=%b rdy=%b, expected 0 0",
               rvalid, ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    count_clear("reclear_len");
    acc(0, 0, 2'b10, 0, 8'h10, '0);
    n_tests++;
    if (rvalid !== 1'b1 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL cleared_0x10: rv=%b rd=%h, expected 1 00000000",
               rvalid, read_data);
    end
  endtask

  initial begin
    test_reset();
    test_bytes();
    test_half();
    test_fault();
    test_depth48();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory for the CPU's load/store path. It supports byte, halfword and word accesses with byte-lane writes, and sign or zero extension on loads. Misaligned and out-of-range accesses are detected and suppressed. After reset, a sequencer zero-fills the whole array before the block accepts any request. It sits between the execute stage's address/store-data outputs and the writeback mux.

## Interface
Parameters:
- DEPTH, 64 — number of 32-bit words; any value 1..2**(ADDR_W-2)
- ADDR_W, 8 — byte-address width; word index = address[ADDR_W-1:2]
- CLEAR_ON_RESET, 1 — 1: zero-fill array after reset; 0: skip fill, contents undefined

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request, sampled at rising edge when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- unsigned_ld  in  1  1 = zero-extend byte/half loads, 0 = sign-extend
- address  in  ADDR_W  byte address
- write_data  in  32  store data; byte/half taken from low bits
- ready  out  1  block idle and accepting requests
- rvalid  out  1  read_data valid (one-cycle pulse)
- read_data  out  32  extended load result
- fault  out  1  one-cycle pulse: last accepted request was illegal and suppressed

## Operation
- FSM states: CLEAR, IDLE.
  - Reset asserted → CLEAR (or IDLE if CLEAR_ON_RESET=0).
  - clr_ptr=0; ready=0, rvalid=0, fault=0, read_data=0.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. The write at clr_ptr=DEPTH-1 moves the FSM to IDLE. req is ignored.
- IDLE: ready=1. A request is accepted at each edge with req=1. There is no back-pressure; back-to-back requests are allowed every cycle.
- Fault conditions (any one suppresses the write/read):
  - size=11
  - half with address[0]=1
  - word with address[1:0]≠0
  - word index ≥ DEPTH
- Store lanes:
  - byte → lane address[1:0] gets write_data[7:0]
  - half → lanes {address[1],0} and {address[1],1} get write_data[15:0]
  - word → all four lanes
  - Other lanes are unchanged.
- Load: the word is read at the accept edge. The selected byte/half is right-aligned and extended to 32 bits per unsigned_ld; word loads ignore unsigned_ld.
- read_data holds its last value when rvalid=0, including after a faulted load.
- A store followed by a load of the same word on the next accepted edge returns the stored data. The write commits at the store edge, so no forwarding is needed.
- Reset mid-operation clears rvalid/fault immediately, discards the in-flight load, and restarts CLEAR from word 0 for the full DEPTH cycles.

## Timing
- Load latency: 1 cycle. Accept at edge k → rvalid=1 with read_data valid from edge k until edge k+1, then rvalid=0 unless a new load was accepted at k+1.
- Store: array updated at the accept edge; no output response unless faulted.
- fault: asserted for the cycle after the accept edge of the illegal request.
- rvalid and fault are never both high.
- Clear duration: exactly DEPTH rising edges after reset deassertion. ready rises after the DEPTH-th edge.
- All outputs are registered.

## Test plan
- Reset release with DEPTH=64 → ready=0 for 64 edges, then 1. Word load at 0x3C → rvalid next cycle, read_data=0x00000000.
- Store word 0xDEADBEEF @0x10, then signed byte loads @0x10..0x13 → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE. Unsigned byte load @0x13 → 0x000000DE. Back-to-back loads give rvalid high 4 consecutive cycles.
- Store word 0xAABBCCDD @0x20, then store half 0x1234 @0x22 → word load @0x20 = 0x1234CCDD. Signed half load @0x20 → 0xFFFFCCDD. Unsigned half load @0x22 → 0x00001234.
- Store word @0x21 → fault pulse 1 cycle, word @0x20 unchanged. Half load @0x23 → fault=1, rvalid=0, read_data unchanged. Load with size=11 → fault.
- DEPTH=48: word load @0xC0 (index 48) → fault. Word store 0x55 @0xBC (index 47), then load → 0x00000055.
- Drop reset asynchronously mid-cycle while a load is in flight → rvalid and ready fall before the next edge. After release, clear takes the full DEPTH edges; previously stored @0x10 reads back 0x00000000.
